// File: rtl/ex_mem_stage_pkg.sv
// ----------------------------------------------------------------------------
// ex_mem_stage_pkg
//   Shared definitions for the EX/MEM pipeline stage: bit positions inside
//   the 6-bit EX control bundle, the width of the bundle forwarded to MEM,
//   the index of the hard-wired zero register, and a helper that resolves
//   BEQ/BNE from the ALU Zero flag.
// ----------------------------------------------------------------------------
package ex_mem_stage_pkg;

  // Control bundle layout: {regwrite, memread, memwrite, memtoreg, beq, bne}
  localparam int CTRL_W        = 6;
  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_BEQ      = 1;
  localparam int CTRL_BNE      = 0;

  // Only the memory/writeback half of the bundle travels past this stage.
  localparam int MEM_CTRL_W    = 4;

  // Register index that never holds a forwardable value.
  localparam int REG_ZERO      = 0;

  // Branch outcome for a resident instruction: BEQ taken on Zero, BNE on !Zero.
  function automatic logic branch_taken(input logic [CTRL_W-1:0] ctrl,
                                        input logic              zero);
    return (ctrl[CTRL_BEQ] & zero) | (ctrl[CTRL_BNE] & ~zero);
  endfunction

endpackage : ex_mem_stage_pkg

// File: rtl/ex_mem_fwd.sv
// ----------------------------------------------------------------------------
// ex_mem_fwd
//   Pure combinational forwarding comparator. Asserts fwd_a / fwd_b when the
//   instruction resident in MEM will write a non-zero register that matches
//   the rs / rt source of the instruction currently in EX. Loads never
//   forward from here; their data is not available until after MEM.
//
// Ports
//   mem_valid     in   MEM holds a live instruction
//   mem_regwrite  in   MEM instruction writes the register file
//   mem_memread   in   MEM instruction is a load
//   mem_rd        in   MEM destination index
//   ex_rs, ex_rt  in   EX source indices
//   fwd_a, fwd_b  out  select mem_alu_out for ALU operand x / y
// ----------------------------------------------------------------------------
module ex_mem_fwd
  import ex_mem_stage_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             mem_valid,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  output logic             fwd_a,
  output logic             fwd_b
);

  logic producer;

  assign producer = mem_valid & mem_regwrite & ~mem_memread
                  & (mem_rd != REG_W'(REG_ZERO));

  assign fwd_a = producer & (mem_rd == ex_rs);
  assign fwd_b = producer & (mem_rd == ex_rt);

endmodule : ex_mem_fwd

// File: rtl/ex_mem_stage.sv
// ----------------------------------------------------------------------------
// ex_mem_stage
//   EX/MEM pipeline register directly downstream of the ALU. Captures the ALU
//   result, Zero flag and EX control bundle, resolves BEQ/BNE in MEM, issues a
//   single-cycle PC redirect per taken branch (even across back-pressure) and
//   squashes the younger instruction sitting in EX during that redirect.
//   Also exports forwarding selects for the EX operand muxes.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   ex_valid          EX holds a live instruction
//   ex_alu_out        ALU result (passes through unmodified)
//   ex_alu_zero       ALU Zero flag
//   ex_rs, ex_rt      EX source indices (forwarding compare)
//   ex_rd             EX destination index
//   ex_ctrl           {regwrite,memread,memwrite,memtoreg,beq,bne}
//   ex_store_data     rt value for stores
//   ex_br_target      computed branch target
//   stall             hold every stage register
//   flush             squash: next captured entry is a bubble
//   mem_valid         stage holds a live instruction
//   mem_alu_out       registered ALU result / memory address
//   mem_store_data    registered store data
//   mem_rd            registered destination
//   mem_ctrl          {regwrite,memread,memwrite,memtoreg}, zero for bubbles
//   redirect          one-cycle pulse: fetch from redirect_pc
//   redirect_pc       registered branch target
//   fwd_a, fwd_b      forward mem_alu_out to ALU operand x / y
// ----------------------------------------------------------------------------
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic [DATA_W-1:0]     ex_alu_out,
  input  logic                  ex_alu_zero,
  input  logic [REG_W-1:0]      ex_rs,
  input  logic [REG_W-1:0]      ex_rt,
  input  logic [REG_W-1:0]      ex_rd,
  input  logic [CTRL_W-1:0]     ex_ctrl,
  input  logic [DATA_W-1:0]     ex_store_data,
  input  logic [DATA_W-1:0]     ex_br_target,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  mem_valid,
  output logic [DATA_W-1:0]     mem_alu_out,
  output logic [DATA_W-1:0]     mem_store_data,
  output logic [REG_W-1:0]      mem_rd,
  output logic [MEM_CTRL_W-1:0] mem_ctrl,
  output logic                  redirect,
  output logic [DATA_W-1:0]     redirect_pc,
  output logic                  fwd_a,
  output logic                  fwd_b
);

  logic              valid_q, valid_d;
  logic              zero_q;
  logic              redirect_done_q, redirect_done_d;
  logic [CTRL_W-1:0] ctrl_q;
  logic [REG_W-1:0]  rd_q;
  logic [DATA_W-1:0] alu_out_q, store_data_q, br_target_q;

  logic capture;
  logic taken;

  assign capture  = ~stall;
  assign taken    = valid_q & branch_taken(ctrl_q, zero_q);
  // redirect_done suppresses a second pulse for the same resident branch.
  assign redirect = taken & ~redirect_done_q & ~stall;

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    valid_d         = valid_q;
    redirect_done_d = redirect_done_q;
    if (capture) begin
      // The instruction in EX during a redirect is on the wrong path.
      valid_d         = ex_valid & ~flush & ~redirect;
      redirect_done_d = 1'b0;
    end
    if (redirect) begin
      redirect_done_d = 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments so all registers sample
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are reset too, because every output
      // (including redirect_pc and mem_alu_out) must read zero after reset.
      valid_q         <= 1'b0;
      zero_q          <= 1'b0;
      redirect_done_q <= 1'b0;
      ctrl_q          <= '0;
      rd_q            <= '0;
      alu_out_q       <= '0;
      store_data_q    <= '0;
      br_target_q     <= '0;
    end else begin
      valid_q         <= valid_d;
      redirect_done_q <= redirect_done_d;
      if (capture) begin
        zero_q       <= ex_alu_zero;
        ctrl_q       <= ex_ctrl;
        rd_q         <= ex_rd;
        alu_out_q    <= ex_alu_out;
        store_data_q <= ex_store_data;
        br_target_q  <= ex_br_target;
      end
    end
  end

  assign mem_valid      = valid_q;
  assign mem_alu_out    = alu_out_q;
  assign mem_store_data = store_data_q;
  assign mem_rd         = rd_q;
  assign redirect_pc    = br_target_q;
  // Bubbles must never write the register file or memory.
  assign mem_ctrl       = valid_q ? ctrl_q[CTRL_REGWRITE:CTRL_MEMTOREG] : '0;

  ex_mem_fwd #(
    .REG_W (REG_W)
  ) u_fwd (
    .mem_valid    (valid_q),
    .mem_regwrite (ctrl_q[CTRL_REGWRITE]),
    .mem_memread  (ctrl_q[CTRL_MEMREAD]),
    .mem_rd       (rd_q),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

endmodule : ex_mem_stage

// File: tb/tb_ex_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_stage
//   Self-checking bench for ex_mem_stage: directed scenarios with constant
//   expectations, then randomized traffic checked against a behavioural model
//   of "which instruction sits in MEM and has its branch already fired".
// ----------------------------------------------------------------------------
module tb_ex_mem_stage;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_alu_out;
  logic              ex_alu_zero;
  logic [REG_W-1:0]  ex_rs, ex_rt, ex_rd;
  logic [5:0]        ex_ctrl;
  logic [DATA_W-1:0] ex_store_data;
  logic [DATA_W-1:0] ex_br_target;
  logic              stall, flush;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_alu_out, mem_store_data;
  logic [REG_W-1:0]  mem_rd;
  logic [3:0]        mem_ctrl;
  logic              redirect;
  logic [DATA_W-1:0] redirect_pc;
  logic              fwd_a, fwd_b;

  int tests_run = 0;
  int tests_failed = 0;

  ex_mem_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_alu_out     (ex_alu_out),
    .ex_alu_zero    (ex_alu_zero),
    .ex_rs          (ex_rs),
    .ex_rt          (ex_rt),
    .ex_rd          (ex_rd),
    .ex_ctrl        (ex_ctrl),
    .ex_store_data  (ex_store_data),
    .ex_br_target   (ex_br_target),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_alu_out    (mem_alu_out),
    .mem_store_data (mem_store_data),
    .mem_rd         (mem_rd),
    .mem_ctrl       (mem_ctrl),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b)
  );

  always #5 clk = ~clk;

  // Control encodings {regwrite,memread,memwrite,memtoreg,beq,bne}
  localparam logic [5:0] C_ALU   = 6'b100000;
  localparam logic [5:0] C_LOAD  = 6'b110100;
  localparam logic [5:0] C_STORE = 6'b001000;
  localparam logic [5:0] C_BEQ   = 6'b000010;
  localparam logic [5:0] C_BNE   = 6'b000001;

  // ---------------- behavioural model ----------------
  // The instruction resident in MEM, described by its meaning rather than
  // by register bits, plus whether its branch has already redirected fetch.
  typedef struct {
    bit              live;
    bit              writes_reg, is_load, is_store, load_to_reg, is_beq, is_bne;
    bit              alu_zero;
    bit              already_redirected;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] result, store_val, target;
  } mem_instr_t;

  mem_instr_t m;

  function automatic bit model_branch_resolves_taken();
    return m.live && ((m.is_beq && m.alu_zero) || (m.is_bne && !m.alu_zero));
  endfunction

  function automatic bit model_redirect();
    return model_branch_resolves_taken() && !m.already_redirected && !stall;
  endfunction

  function automatic logic [3:0] model_mem_ctrl();
    if (!m.live) return 4'b0000;
    return {m.writes_reg, m.is_load, m.is_store, m.load_to_reg};
  endfunction

  function automatic bit model_fwd(input logic [REG_W-1:0] src);
    return m.live && m.writes_reg && !m.is_load && m.dest != 0 && m.dest == src;
  endfunction

  // Advance one clock: update the model from the inputs seen at this edge,
  // then let the DUT take the edge and settle.
  task automatic cycle();
    bit fire;
    fire = model_redirect();
    if (rst) begin
      m = '{default: 0};
    end else if (!stall) begin
      m.live               = ex_valid && !flush && !fire;
      m.writes_reg         = ex_ctrl[5];
      m.is_load            = ex_ctrl[4];
      m.is_store           = ex_ctrl[3];
      m.load_to_reg        = ex_ctrl[2];
      m.is_beq             = ex_ctrl[1];
      m.is_bne             = ex_ctrl[0];
      m.alu_zero           = ex_alu_zero;
      m.dest               = ex_rd;
      m.result             = ex_alu_out;
      m.store_val          = ex_store_data;
      m.target             = ex_br_target;
      m.already_redirected = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    rst = 0; stall = 0; flush = 0;
    ex_valid = 0; ex_alu_out = '0; ex_alu_zero = 0;
    ex_rs = '0; ex_rt = '0; ex_rd = '0; ex_ctrl = '0;
    ex_store_data = '0; ex_br_target = '0;
  endtask

  task automatic drive_instr(input logic [5:0] ctrl, input logic [DATA_W-1:0] alu,
                             input logic zero, input logic [REG_W-1:0] rd,
                             input logic [DATA_W-1:0] sd, input logic [DATA_W-1:0] tgt);
    ex_valid = 1; ex_ctrl = ctrl; ex_alu_out = alu; ex_alu_zero = zero;
    ex_rd = rd; ex_store_data = sd; ex_br_target = tgt;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    drive_idle();
    ex_valid = 1; ex_ctrl = C_ALU; ex_alu_out = 32'hDEAD_BEEF; ex_rd = 5'd9;
    ex_br_target = 32'h1234; stall = 1; flush = 1;
    rst = 1;
    cycle();
    cycle();
    tests_run++;
    if ({mem_valid, mem_alu_out, mem_store_data, mem_rd, mem_ctrl, redirect,
         redirect_pc, fwd_a, fwd_b} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: valid=%0b alu=%h sd=%h rd=%0d ctrl=%b redir=%0b pc=%h fwd=%0b%0b required all zero",
               mem_valid, mem_alu_out, mem_store_data, mem_rd, mem_ctrl, redirect, redirect_pc, fwd_a, fwd_b);
    end
    drive_idle();
    cycle();
  endtask

  task automatic test_alu_capture();
    logic [DATA_W-1:0] sum;
    drive_idle();
    sum = 32'(5 + 7);
    drive_instr(C_ALU, sum, 1'b0, 5'd3, 32'h0, 32'h0);
    cycle();
    drive_idle();
    #1;
    tests_run++;
    if (mem_alu_out !== 32'd12 || mem_rd !== 5'd3 || mem_ctrl !== 4'b1000 || mem_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL add_capture: alu=%0d rd=%0d ctrl=%b valid=%0b required alu=12 rd=3 ctrl=1000 valid=1",
               mem_alu_out, mem_rd, mem_ctrl, mem_valid);
    end
    // Negative result and store data pass through with sign bits intact.
    drive_instr(C_STORE, 32'hFFFF_FFF6, 1'b0, 5'd0, 32'h8000_0001, 32'h0);
    cycle();
    drive_idle();
    #1;
    tests_run++;
    if (mem_alu_out !== 32'hFFFF_FFF6 || mem_store_data !== 32'h8000_0001 || mem_ctrl !== 4'b0010) begin
      tests_failed++;
      $display("FAIL store_passthru: alu=%h sd=%h ctrl=%b required alu=fffffff6 sd=80000001 ctrl=0010",
               mem_alu_out, mem_store_data, mem_ctrl);
    end
  endtask

  task automatic test_beq_redirect();
    drive_idle();
    drive_instr(C_BEQ, 32'h0, 1'b1, 5'd0, 32'h0, 32'h40);
    cycle();
    // Younger instruction arrives in EX during the redirect cycle.
    drive_instr(C_ALU, 32'h77, 1'b0, 5'd4, 32'h0, 32'h0);
    #1;
    tests_run++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h40) begin
      tests_failed++;
      $display("FAIL beq_redirect: redirect=%0b pc=%h required redirect=1 pc=00000040", redirect, redirect_pc);
    end
    cycle();
    drive_idle();
    #1;
    tests_run++;
    if (mem_valid !== 1'b0 || mem_ctrl !== 4'b0000 || redirect !== 1'b0) begin
      tests_failed++;
      $display("FAIL beq_squash: valid=%0b ctrl=%b redirect=%0b required 0 0000 0", mem_valid, mem_ctrl, redirect);
    end
  endtask

  task automatic test_bne_stall();
    int pulses;
    drive_idle();
    drive_instr(C_BNE, 32'h0, 1'b1, 5'd0, 32'h0, 32'h80);
    cycle();
    drive_idle();
    #1;
    tests_run++;
    if (redirect !== 1'b0) begin
      tests_failed++;
      $display("FAIL bne_not_taken: redirect=%0b required 0", redirect);
    end
    drive_instr(C_BNE, 32'h5, 1'b0, 5'd0, 32'h0, 32'h100);
    cycle();
    stall = 1;
    ex_alu_out = 32'h99; ex_br_target = 32'h200;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (redirect === 1'b1) pulses++;
      cycle();
    end
    stall = 0;
    ex_valid = 0;
    #1;
    tests_run++;
    if (pulses !== 0) begin
      tests_failed++;
      $display("FAIL bne_stalled_pulses: pulses=%0d required 0", pulses);
    end
    tests_run++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h100) begin
      tests_failed++;
      $display("FAIL bne_after_stall: redirect=%0b pc=%h required redirect=1 pc=00000100", redirect, redirect_pc);
    end
    cycle();
    #1;
    tests_run++;
    if (redirect !== 1'b0) begin
      tests_failed++;
      $display("FAIL bne_single_pulse: redirect=%0b required 0", redirect);
    end
  endtask

  task automatic test_forwarding();
    drive_idle();
    drive_instr(C_ALU, 32'h55, 1'b0, 5'd8, 32'h0, 32'h0);
    cycle();
    drive_idle();
    ex_rs = 5'd8; ex_rt = 5'd8;
    #1;
    tests_run++;
    if (fwd_a !== 1'b1 || fwd_b !== 1'b1) begin
      tests_failed++;
      $display("FAIL fwd_both: fwd_a=%0b fwd_b=%0b required 1 1", fwd_a, fwd_b);
    end
    ex_rt = 5'd9;
    #1;
    tests_run++;
    if (fwd_a !== 1'b1 || fwd_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL fwd_a_only: fwd_a=%0b fwd_b=%0b required 1 0", fwd_a, fwd_b);
    end
    drive_instr(C_ALU, 32'h55, 1'b0, 5'd0, 32'h0, 32'h0);
    cycle();
    drive_idle();
    ex_rs = 5'd0; ex_rt = 5'd0;
    #1;
    tests_run++;
    if (fwd_a !== 1'b0 || fwd_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL fwd_r0: fwd_a=%0b fwd_b=%0b required 0 0", fwd_a, fwd_b);
    end
    drive_instr(C_LOAD, 32'h1000, 1'b0, 5'd8, 32'h0, 32'h0);
    cycle();
    drive_idle();
    ex_rs = 5'd8; ex_rt = 5'd8;
    #1;
    tests_run++;
    if (fwd_a !== 1'b0 || fwd_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL fwd_load: fwd_a=%0b fwd_b=%0b required 0 0", fwd_a, fwd_b);
    end
  endtask

  task automatic test_stall_flush();
    int changed;
    drive_idle();
    drive_instr(C_STORE, 32'hA5A5, 1'b0, 5'd7, 32'h1234, 32'h0);
    cycle();
    stall = 1;
    changed = 0;
    for (int i = 0; i < 3; i++) begin
      drive_instr(C_ALU, $urandom, 1'b1, 5'(i + 10), $urandom, $urandom);
      flush = (i == 1);
      cycle();
      #1;
      if (mem_valid !== 1'b1 || mem_alu_out !== 32'hA5A5 || mem_store_data !== 32'h1234 ||
          mem_rd !== 5'd7 || mem_ctrl !== 4'b0010) changed++;
    end
    tests_run++;
    if (changed !== 0) begin
      tests_failed++;
      $display("FAIL stall_hold: %0d stalled cycles changed outputs, required 0 (last alu=%h rd=%0d)",
               changed, mem_alu_out, mem_rd);
    end
    stall = 0; flush = 1;
    drive_instr(C_ALU, 32'h42, 1'b0, 5'd5, 32'h0, 32'h0);
    cycle();
    drive_idle();
    #1;
    tests_run++;
    if (mem_valid !== 1'b0 || mem_ctrl !== 4'b0000) begin
      tests_failed++;
      $display("FAIL flush_bubble: valid=%0b ctrl=%b required 0 0000", mem_valid, mem_ctrl);
    end
  endtask

  task automatic test_reset_mid_redirect();
    drive_idle();
    drive_instr(C_BEQ, 32'h0, 1'b1, 5'd0, 32'h0, 32'hC0);
    cycle();
    stall = 1;
    cycle();
    rst = 1;
    cycle();
    rst = 0; stall = 0; ex_valid = 0;
    #1;
    tests_run++;
    if ({mem_valid, mem_alu_out, mem_rd, mem_ctrl, redirect, redirect_pc} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_branch: valid=%0b rd=%0d ctrl=%b redirect=%0b pc=%h required all zero",
               mem_valid, mem_rd, mem_ctrl, redirect, redirect_pc);
    end
    cycle();
    #1;
    tests_run++;
    if (redirect !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_no_pending: redirect=%0b required 0", redirect);
    end
  endtask

  // ---------------- randomized traffic vs model ----------------
  task automatic test_random();
    int errs;
    drive_idle();
    rst = 1;
    cycle();
    rst = 0;
    errs = 0;
    for (int n = 0; n < 600; n++) begin
      ex_valid      = ($urandom_range(0, 9) < 8);
      ex_alu_out    = $urandom;
      ex_alu_zero   = $urandom_range(0, 1);
      ex_rs         = 5'($urandom_range(0, 3));
      ex_rt         = 5'($urandom_range(0, 3));
      ex_rd         = 5'($urandom_range(0, 3));
      ex_ctrl       = 6'($urandom);
      ex_store_data = $urandom;
      ex_br_target  = $urandom;
      stall         = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      rst           = ($urandom_range(0, 49) == 0);
      #1;
      tests_run++;
      if (mem_valid !== m.live || mem_ctrl !== model_mem_ctrl() || mem_rd !== m.dest ||
          mem_alu_out !== m.result || mem_store_data !== m.store_val ||
          redirect_pc !== m.target || redirect !== model_redirect() ||
          fwd_a !== model_fwd(ex_rs) || fwd_b !== model_fwd(ex_rt)) begin
        tests_failed++;
        errs++;
        if (errs <= 5)
          $display("FAIL random_cycle_%0d: valid=%0b ctrl=%b rd=%0d alu=%h redir=%0b pc=%h fwd=%0b%0b required valid=%0b ctrl=%b rd=%0d alu=%h redir=%0b pc=%h fwd=%0b%0b",
                   n, mem_valid, mem_ctrl, mem_rd, mem_alu_out, redirect, redirect_pc, fwd_a, fwd_b,
                   m.live, model_mem_ctrl(), m.dest, m.result, model_redirect(), m.target,
                   model_fwd(ex_rs), model_fwd(ex_rt));
      end
      cycle();
    end
    drive_idle();
  endtask

  initial begin
    m = '{default: 0};
    drive_idle();
    rst = 1;
    test_reset();
    test_alu_capture();
    test_beq_redirect();
    test_bne_stall();
    test_forwarding();
    test_stall_flush();
    test_reset_mid_redirect();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_ex_mem_stage
